// File: rtl/rr_arbiter4_pkg.sv
// Shared definitions for the 4-requester round-robin arbiter.
package rr_arbiter4_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam int NREQ         = 4;
    localparam int MAX_HOLD_DEF = 8;
    localparam int CNT_W_DEF    = 4;

endpackage

// File: rtl/rr_arbiter4_decoder2_4.sv
// Shared 2-to-4 enable decoder: one-hot select from an index plus enable.
module decoder2_4 (
    input  logic [1:0] x,
    input  logic       en,
    output logic [3:0] d
);

    always_comb begin
        d = '0;
        if (en) d[x] = 1'b1;
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter for 4 requesters with grant held until release.
// Define ARB_TIMEOUT_EN to force a release after MAX_HOLD cycles when others wait.
module rr_arbiter4
    import rr_arbiter4_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] gnt_id,
    output logic       busy,
    output logic       preempt
);

    if (MAX_HOLD < 1 || MAX_HOLD > (1 << CNT_W) - 1) begin : g_bad_max_hold
        $error("rr_arbiter4: MAX_HOLD out of range for CNT_W");
    end

    state_t     state, state_n;
    logic [1:0] owner, owner_n;
    logic [1:0] last, last_n;
    logic [1:0] pick;
    logic [3:0] owner_oh;

    assign owner_oh = 4'b0001 << owner;

    // Rotating priority: search starts just after the last released owner.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = last + 2'(i);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] hold_cnt, hold_n;
    logic             preempt_q, preempt_n;
    logic             others_wait;

    assign others_wait = |(req & ~owner_oh);
    assign preempt     = preempt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt  <= '0;
            preempt_q <= 1'b0;
        end else begin
            hold_cnt  <= hold_n;
            preempt_q <= preempt_n;
        end
    end
`else
    assign preempt = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            owner <= 2'd0;
            last  <= 2'd3;
        end else begin
            state <= state_n;
            owner <= owner_n;
            last  <= last_n;
        end
    end

    always_comb begin
        state_n = state;
        owner_n = owner;
        last_n  = last;
`ifdef ARB_TIMEOUT_EN
        hold_n    = hold_cnt;
        preempt_n = 1'b0;
`endif
        unique case (state)
            ST_IDLE: begin
                if (|req) begin
                    state_n = ST_GRANT;
                    owner_n = pick;
`ifdef ARB_TIMEOUT_EN
                    hold_n  = CNT_W'(1);
`endif
                end
            end
            ST_GRANT: begin
                if (!req[owner]) begin
                    state_n = ST_IDLE;
                    last_n  = owner;
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_cnt == CNT_W'(MAX_HOLD) && others_wait) begin
                    state_n   = ST_IDLE;
                    last_n    = owner;
                    preempt_n = 1'b1;
                end else if (hold_cnt != CNT_W'(MAX_HOLD)) begin
                    hold_n = hold_cnt + 1'b1;
                end
`endif
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state == ST_GRANT);
        gnt_id = owner;
    end

    decoder2_4 u_dec (
        .x  (owner),
        .en (busy),
        .d  (grant)
    );

endmodule
